// File: rtl/serial_link_vc_credit_scheduler.sv
// Per-VC credit scheduler for the serial link NoC bridge transmit path.
// Round-robin flit grant with piggybacked or forced credit returns.
module serial_link_vc_credit_scheduler #(
   parameter int NumVc           = 2,
   parameter int NumCredits      = 8,
   parameter int ForceSendThresh = NumCredits - 4,
   parameter int IdleTimeout     = 16,
   parameter int CntWidth        = $clog2(NumCredits + 1),
   parameter int VcIdxWidth      = $clog2(NumVc)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumVc-1:0]          data_valid_i,
   output logic [NumVc-1:0]          data_ready_o,
   input  logic [NumVc-1:0]          buf_pop_i,
   input  logic                      cred_rcvd_valid_i,
   input  logic [VcIdxWidth-1:0]     cred_rcvd_vc_i,
   input  logic [CntWidth-1:0]       cred_rcvd_i,
   output logic                      pkt_valid_o,
   input  logic                      pkt_ready_i,
   output logic                      pkt_data_valid_o,
   output logic [VcIdxWidth-1:0]     pkt_data_vc_o,
   output logic [VcIdxWidth-1:0]     pkt_cred_vc_o,
   output logic [CntWidth-1:0]       pkt_cred_o,
   output logic [NumVc*CntWidth-1:0] remote_cred_o,
   output logic                      err_o
);

   localparam int SumWidth  = CntWidth + 1;
   localparam int IdleWidth = $clog2(IdleTimeout);
   localparam logic [SumWidth-1:0]   Full    = SumWidth'(NumCredits);
   localparam logic [CntWidth-1:0]   Thresh  = CntWidth'(ForceSendThresh);
   localparam logic [IdleWidth-1:0]  IdleMax = IdleWidth'(IdleTimeout - 1);
   localparam logic [VcIdxWidth-1:0] LastVc  = VcIdxWidth'(NumVc - 1);

   logic [CntWidth-1:0]   rc [NumVc];
   logic [CntWidth-1:0]   pc [NumVc];
   logic [CntWidth-1:0]   rc_nxt [NumVc];
   logic [CntWidth-1:0]   pc_nxt [NumVc];
   logic [NumVc-1:0]      rc_ovf;
   logic [NumVc-1:0]      pc_ovf;
   logic [VcIdxWidth-1:0] ptr;
   logic [VcIdxWidth-1:0] winner;
   logic [VcIdxWidth-1:0] cv;
   logic [CntWidth-1:0]   best;
   logic [NumVc-1:0]      eligible;
   logic [NumVc-1:0]      grant;
   logic [IdleWidth-1:0]  idle_cnt;
   logic                  load;
   logic                  any_elig;
   logic                  any_pc;
   logic                  force_send;
   logic                  send_data;
   logic                  send_cred;
   logic                  send;

   assign load = !pkt_valid_o | pkt_ready_i;

   always_comb begin
      eligible = '0;
      any_pc   = 1'b0;
      for (int v = 0; v < NumVc; v++) begin
         eligible[v] = data_valid_i[v] & (rc[v] != '0);
         any_pc      = any_pc | (pc[v] != '0);
      end
   end

   assign any_elig = |eligible;

   // round-robin search starting at ptr, wrapping past the last VC
   always_comb begin
      int   idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NumVc; k++) begin
         idx = (int'(ptr) + k) % NumVc;
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = VcIdxWidth'(idx);
         end
      end
   end

   // largest owed count, strict compare keeps the lowest index on ties
   always_comb begin
      best = pc[0];
      cv   = '0;
      for (int v = 1; v < NumVc; v++) begin
         if (pc[v] > best) begin
            best = pc[v];
            cv   = VcIdxWidth'(v);
         end
      end
   end

   assign force_send = (best >= Thresh) | ((idle_cnt == IdleMax) & any_pc);
   assign send_data  = load & any_elig & !rst_i;
   assign send_cred  = load & !any_elig & force_send & !rst_i;
   assign send       = send_data | send_cred;

   always_comb begin
      grant = '0;
      if (send_data) begin
         grant[winner] = 1'b1;
      end
   end

   assign data_ready_o = grant;

   always_comb begin
      logic [SumWidth-1:0] rsum;
      logic [SumWidth-1:0] psum;
      rsum = '0;
      psum = '0;
      for (int v = 0; v < NumVc; v++) begin
         rsum = {1'b0, rc[v]} - SumWidth'(grant[v]);
         if (cred_rcvd_valid_i && cred_rcvd_vc_i == VcIdxWidth'(v)) begin
            rsum = rsum + {1'b0, cred_rcvd_i};
         end
         rc_ovf[v] = rsum > Full;
         rc_nxt[v] = rc_ovf[v] ? Full[CntWidth-1:0] : rsum[CntWidth-1:0];
         psum = (send && cv == VcIdxWidth'(v)) ? '0 : {1'b0, pc[v]};
         psum = psum + SumWidth'(buf_pop_i[v]);
         pc_ovf[v] = psum > Full;
         pc_nxt[v] = pc_ovf[v] ? Full[CntWidth-1:0] : psum[CntWidth-1:0];
      end
   end

   always_comb begin
      remote_cred_o = '0;
      for (int v = 0; v < NumVc; v++) begin
         remote_cred_o[v*CntWidth +: CntWidth] = rc[v];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int v = 0; v < NumVc; v++) begin
            rc[v] <= Full[CntWidth-1:0];
            pc[v] <= '0;
         end
         err_o <= 1'b0;
      end else begin
         for (int v = 0; v < NumVc; v++) begin
            rc[v] <= rc_nxt[v];
            pc[v] <= pc_nxt[v];
         end
         if (|rc_ovf || |pc_ovf) begin
            err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr      <= '0;
         idle_cnt <= '0;
      end else begin
         if (send_data) begin
            ptr <= (winner == LastVc) ? '0 : winner + 1'b1;
         end
         if (send || !any_pc) begin
            idle_cnt <= '0;
         end else if (idle_cnt != IdleMax) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

   // fields hold while the slot is stalled; an empty load only drops valid
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pkt_valid_o      <= 1'b0;
         pkt_data_valid_o <= 1'b0;
         pkt_data_vc_o    <= '0;
         pkt_cred_vc_o    <= '0;
         pkt_cred_o       <= '0;
      end else if (load) begin
         pkt_valid_o <= send;
         if (send) begin
            pkt_data_valid_o <= send_data;
            pkt_data_vc_o    <= send_data ? winner : '0;
            pkt_cred_vc_o    <= cv;
            pkt_cred_o       <= best;
         end
      end
   end

endmodule
